// File: rtl/avst_width_conv.sv
// -----------------------------------------------------------------------------
// avst_width_conv
//   Avalon-ST width converter. Converts IN_BYTES-symbol beats to OUT_BYTES-symbol
//   beats for any integer ratio, up or down. It carries sop/eop/channel through
//   and recomputes empty so that it stays accurate for each packet.
//   Symbol 0 is in the MSBs of both data buses.
//
//   DOWN  (IN_BYTES > OUT_BYTES): holds one input beat and emits it as slices,
//         MSB first. A short eop beat emits only the slices that hold valid
//         symbols.
//   UP    (IN_BYTES < OUT_BYTES): packs input beats MSB first into a word. The
//         word closes when it is full or on eop.
//   EQUAL (IN_BYTES == OUT_BYTES): a 1-deep register stage.
//
// Optional feature (compile-time macro AVST_WCOV_ERR_EN):
//   When defined, adds the avst_err port. avst_err is a sticky protocol-error
//   flag set by any of: sop inside a packet, a non-sop beat outside a packet,
//   or nonzero empty without eop. It stays high until reset.
//   When undefined, there is no port and no checking logic.
//
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   avst_in_*                 sink side   (ready/valid/data/empty/sop/eop/channel)
//   avst_out_*                source side (ready/valid/data/empty/sop/eop/channel)
//   avst_err                  sticky protocol error (AVST_WCOV_ERR_EN only)
// -----------------------------------------------------------------------------
module avst_width_conv #(
  parameter  int IN_BYTES  = 64,
  parameter  int OUT_BYTES = 16,
  parameter  int SYM_W     = 8,
  parameter  int CH_W      = 128,
  localparam int IN_EW     = (IN_BYTES  > 1) ? $clog2(IN_BYTES)  : 1,
  localparam int OUT_EW    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1,
  localparam int IN_W      = IN_BYTES  * SYM_W,
  localparam int OUT_W     = OUT_BYTES * SYM_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              avst_in_ready,
  input  logic              avst_in_valid,
  input  logic [IN_W-1:0]   avst_in_data,
  input  logic [IN_EW-1:0]  avst_in_empty,
  input  logic              avst_in_sop,
  input  logic              avst_in_eop,
  input  logic [CH_W-1:0]   avst_in_channel,
  input  logic              avst_out_ready,
  output logic              avst_out_valid,
  output logic [OUT_W-1:0]  avst_out_data,
  output logic [OUT_EW-1:0] avst_out_empty,
  output logic              avst_out_sop,
  output logic              avst_out_eop,
`ifdef AVST_WCOV_ERR_EN
  output logic              avst_err,
`endif
  output logic [CH_W-1:0]   avst_out_channel
);

  typedef enum logic {DN_IDLE, DN_DRAIN} dn_state_t;
  typedef enum logic {UP_ACC,  UP_FULL}  up_state_t;

  logic in_fire;
  logic out_fire;

  assign in_fire  = avst_in_valid  && avst_in_ready;
  assign out_fire = avst_out_valid && avst_out_ready;

  generate
    if (IN_BYTES > OUT_BYTES) begin : g_down
      // -----------------------------------------------------------------------
      // DOWN: one held beat drained as up to R slices
      // -----------------------------------------------------------------------
      localparam int R  = IN_BYTES / OUT_BYTES;
      localparam int NW = $clog2(R + 1);

      dn_state_t          state, state_nx;
      logic [IN_W-1:0]    hold_data;
      logic               hold_sop, hold_eop;
      logic [OUT_EW-1:0]  hold_empty;   // empty of the final slice
      logic [CH_W-1:0]    hold_ch;
      logic [NW-1:0]      hold_n;       // slices to emit for the held beat
      logic [NW-1:0]      k;            // current slice index
      logic               last_slice;
      logic [IN_EW:0]     in_valid_syms;
      logic [NW-1:0]      in_n;
      logic [OUT_EW-1:0]  in_last_empty;

      // Slice count and the empty of the final slice, computed at accept time.
      // A non-eop beat is always full width, so it drains all R slices.
      // NOTE: every always_comb output gets a value on every path, here by
      // straight-line assignment, so no latch can be inferred.
      always_comb begin
        in_valid_syms = avst_in_eop ? (IN_EW+1)'(IN_BYTES) - {1'b0, avst_in_empty}
                                    : (IN_EW+1)'(IN_BYTES);
        in_n          = NW'((32'(in_valid_syms) + 32'(OUT_BYTES - 1)) / 32'(OUT_BYTES));
        in_last_empty = OUT_EW'(32'(in_n) * 32'(OUT_BYTES) - 32'(in_valid_syms));
      end

      assign last_slice = (state == DN_DRAIN) && (k == hold_n - NW'(1));

      // State register
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples its inputs from before the edge regardless of block order.
      always_ff @(posedge clk) begin
        if (reset) state <= DN_IDLE;
        else       state <= state_nx;
      end

      // Next-state logic
      always_comb begin
        state_nx = state;
        case (state)
          DN_IDLE:  if (in_fire) state_nx = DN_DRAIN;
          DN_DRAIN: if (out_fire && last_slice && !in_fire) state_nx = DN_IDLE;
          default:  state_nx = DN_IDLE;
        endcase
      end

      // Outputs. The next beat is accepted in the same cycle the final slice
      // leaves, so back-to-back beats drain with no bubble.
      always_comb begin
        avst_in_ready    = !reset && ((state == DN_IDLE) || (last_slice && avst_out_ready));
        avst_out_valid   = (state == DN_DRAIN);
        avst_out_data    = hold_data[IN_W-1 - int'(k)*OUT_W -: OUT_W];
        avst_out_sop     = (state == DN_DRAIN) && hold_sop && (k == '0);
        avst_out_eop     = last_slice && hold_eop;
        avst_out_empty   = last_slice ? hold_empty : '0;
        avst_out_channel = hold_ch;
      end

      // Hold register and slice index
      // NOTE: the datapath registers are reset too, because the outputs must
      // read as zero out of reset, not just be marked invalid.
      always_ff @(posedge clk) begin
        if (reset) begin
          hold_data  <= '0;
          hold_sop   <= 1'b0;
          hold_eop   <= 1'b0;
          hold_empty <= '0;
          hold_ch    <= '0;
          hold_n     <= '0;
          k          <= '0;
        end else if (in_fire) begin
          hold_data  <= avst_in_data;
          hold_sop   <= avst_in_sop;
          hold_eop   <= avst_in_eop;
          hold_empty <= in_last_empty;
          hold_ch    <= avst_in_channel;
          hold_n     <= in_n;
          k          <= '0;
        end else if (out_fire) begin
          k <= last_slice ? '0 : k + NW'(1);
        end
      end

    end else if (IN_BYTES < OUT_BYTES) begin : g_up
      // -----------------------------------------------------------------------
      // UP: pack R beats (or fewer, up to eop) into one output word
      // -----------------------------------------------------------------------
      localparam int R  = OUT_BYTES / IN_BYTES;
      localparam int CW = (R > 1) ? $clog2(R) : 1;

      up_state_t          state, state_nx;
      logic [CW-1:0]      cnt;
      logic [OUT_W-1:0]   acc_data, acc_next;
      logic               acc_sop;
      logic [CH_W-1:0]    acc_ch;
      logic               closing;
      logic [OUT_EW-1:0]  close_empty;
      logic [OUT_W-1:0]   word_data;
      logic               word_sop, word_eop;
      logic [OUT_EW-1:0]  word_empty;
      logic [CH_W-1:0]    word_ch;

      // Place the incoming beat into its slot. A new word starts from zero,
      // so the slots of a short final word read as zero.
      always_comb begin
        closing  = avst_in_eop || (cnt == CW'(R - 1));
        acc_next = (cnt == '0) ? '0 : acc_data;
        acc_next[OUT_W-1 - int'(cnt)*IN_W -: IN_W] = avst_in_data;
        close_empty = avst_in_eop
          ? OUT_EW'(OUT_BYTES - ((int'(cnt) + 1) * IN_BYTES - int'(avst_in_empty)))
          : '0;
      end

      // State register
      always_ff @(posedge clk) begin
        if (reset) state <= UP_ACC;
        else       state <= state_nx;
      end

      // Next-state logic: FULL while a closed word waits in the output register
      always_comb begin
        state_nx = state;
        case (state)
          UP_ACC:  if (in_fire && closing) state_nx = UP_FULL;
          UP_FULL: if (out_fire && !(in_fire && closing)) state_nx = UP_ACC;
          default: state_nx = UP_ACC;
        endcase
      end

      // Outputs
      always_comb begin
        avst_in_ready    = !reset && ((state == UP_ACC) || avst_out_ready);
        avst_out_valid   = (state == UP_FULL);
        avst_out_data    = word_data;
        avst_out_sop     = word_sop;
        avst_out_eop     = word_eop;
        avst_out_empty   = word_empty;
        avst_out_channel = word_ch;
      end

      // Accumulator and output word register. sop and channel come from the
      // first beat of the word.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt        <= '0;
          acc_data   <= '0;
          acc_sop    <= 1'b0;
          acc_ch     <= '0;
          word_data  <= '0;
          word_sop   <= 1'b0;
          word_eop   <= 1'b0;
          word_empty <= '0;
          word_ch    <= '0;
        end else if (in_fire) begin
          if (closing) begin
            word_data  <= acc_next;
            word_sop   <= (cnt == '0) ? avst_in_sop     : acc_sop;
            word_ch    <= (cnt == '0) ? avst_in_channel : acc_ch;
            word_eop   <= avst_in_eop;
            word_empty <= close_empty;
            cnt        <= '0;
          end else begin
            acc_data <= acc_next;
            cnt      <= cnt + CW'(1);
            if (cnt == '0) begin
              acc_sop <= avst_in_sop;
              acc_ch  <= avst_in_channel;
            end
          end
        end
      end

    end else begin : g_equal
      // -----------------------------------------------------------------------
      // EQUAL: single register stage at full throughput
      // -----------------------------------------------------------------------
      logic              valid_q;
      logic [OUT_W-1:0]  data_q;
      logic              sop_q, eop_q;
      logic [OUT_EW-1:0] empty_q;
      logic [CH_W-1:0]   ch_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          sop_q   <= 1'b0;
          eop_q   <= 1'b0;
          empty_q <= '0;
          ch_q    <= '0;
        end else if (in_fire) begin
          valid_q <= 1'b1;
          data_q  <= avst_in_data;
          sop_q   <= avst_in_sop;
          eop_q   <= avst_in_eop;
          empty_q <= avst_in_empty;
          ch_q    <= avst_in_channel;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end

      always_comb begin
        avst_in_ready    = !reset && (!valid_q || avst_out_ready);
        avst_out_valid   = valid_q;
        avst_out_data    = data_q;
        avst_out_sop     = sop_q;
        avst_out_eop     = eop_q;
        avst_out_empty   = empty_q;
        avst_out_channel = ch_q;
      end
    end
  endgenerate

`ifdef AVST_WCOV_ERR_EN
  // Input-side packet tracker. It only observes; beats are converted as given.
  logic in_pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt   <= 1'b0;
      avst_err <= 1'b0;
    end else if (in_fire) begin
      if ((avst_in_sop && in_pkt) || (!avst_in_sop && !in_pkt) ||
          ((avst_in_empty != '0) && !avst_in_eop))
        avst_err <= 1'b1;
      in_pkt <= !avst_in_eop;
    end
  end
`endif

endmodule
